// File: rtl/l1_l2_req_arb.sv
// rtl/l1_l2_req_arb.sv - round-robin L1 stream request arbiter with L2 credit limit and response routing
module l1_l2_req_arb #(
    parameter int nstrms    = 64,
    parameter int sid_width = $clog2(nstrms),
    parameter int max_out   = 8,
    parameter int cnt_width = $clog2(max_out + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [nstrms-1:0]    i_req_v,
    output logic [nstrms-1:0]    i_req_r,
    output logic                 o_req_v,
    input  logic                 o_req_r,
    output logic [sid_width-1:0] o_req_sid,
    input  logic                 i_rsp_v,
    output logic                 i_rsp_r,
    input  logic [sid_width-1:0] i_rsp_sid,
    output logic [nstrms-1:0]    o_rsp_v,
    input  logic [nstrms-1:0]    o_rsp_r,
    output logic                 o_err,
    output logic [cnt_width-1:0] o_out_cnt
);

    localparam logic [cnt_width-1:0] MAX_OUT_C = cnt_width'(max_out);
    localparam logic [nstrms-1:0]    ONE_HOT_0 = nstrms'(1);

    logic [nstrms-1:0]    pend_q, pend_d;
    logic [sid_width-1:0] rr_ptr_q, rr_ptr_d;
    logic [cnt_width-1:0] out_cnt_q, out_cnt_d;
    logic                 req_v_q, req_v_d;
    logic [sid_width-1:0] req_sid_q, req_sid_d;
    logic                 rsp_v_q, rsp_v_d;
    logic [sid_width-1:0] rsp_sid_q, rsp_sid_d;
    logic                 rsp_ok_q, rsp_ok_d;
    logic                 err_q, err_d;

    logic [nstrms-1:0]    eligible;
    logic                 found;
    logic [sid_width-1:0] grant_sid;
    logic [sid_width-1:0] idx;
    logic                 grant;
    logic                 rsp_hs;
    logic                 rsp_acc;
    logic                 cnt_dec;

    assign eligible = i_req_v & ~pend_q;

    // Rotating priority search; sid arithmetic wraps because nstrms is a power of two.
    always_comb begin
        found     = 1'b0;
        grant_sid = rr_ptr_q;
        idx       = '0;
        for (int i = 0; i < nstrms; i++) begin
            idx = rr_ptr_q + sid_width'(i);
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_sid = idx;
            end
        end
    end

    assign grant   = !reset && found && (out_cnt_q < MAX_OUT_C) && (!req_v_q || o_req_r);
    assign rsp_hs  = rsp_v_q && o_rsp_r[rsp_sid_q];
    assign i_rsp_r = !reset && (!rsp_v_q || rsp_hs);
    assign rsp_acc = i_rsp_v && i_rsp_r;
    // Responses that arrived for an idle stream are delivered but never touch the accounting.
    assign cnt_dec = rsp_hs && rsp_ok_q && (out_cnt_q != '0);

    always_comb begin
        pend_d    = pend_q;
        rr_ptr_d  = rr_ptr_q;
        out_cnt_d = out_cnt_q;
        req_v_d   = req_v_q;
        req_sid_d = req_sid_q;
        rsp_v_d   = rsp_v_q;
        rsp_sid_d = rsp_sid_q;
        rsp_ok_d  = rsp_ok_q;
        err_d     = err_q;

        if (rsp_hs && rsp_ok_q) begin
            pend_d[rsp_sid_q] = 1'b0;
        end
        if (grant) begin
            pend_d[grant_sid] = 1'b1;
            rr_ptr_d          = grant_sid + sid_width'(1);
            req_v_d           = 1'b1;
            req_sid_d         = grant_sid;
        end else if (o_req_r) begin
            req_v_d = 1'b0;
        end

        if (grant && !cnt_dec) begin
            out_cnt_d = out_cnt_q + cnt_width'(1);
        end else if (!grant && cnt_dec) begin
            out_cnt_d = out_cnt_q - cnt_width'(1);
        end

        if (rsp_acc) begin
            rsp_v_d   = 1'b1;
            rsp_sid_d = i_rsp_sid;
            rsp_ok_d  = pend_q[i_rsp_sid];
            if (!pend_q[i_rsp_sid]) begin
                err_d = 1'b1;
            end
        end else if (rsp_hs) begin
            rsp_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q    <= '0;
            rr_ptr_q  <= '0;
            out_cnt_q <= '0;
            req_v_q   <= 1'b0;
            req_sid_q <= '0;
            rsp_v_q   <= 1'b0;
            rsp_sid_q <= '0;
            rsp_ok_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            rr_ptr_q  <= rr_ptr_d;
            out_cnt_q <= out_cnt_d;
            req_v_q   <= req_v_d;
            req_sid_q <= req_sid_d;
            rsp_v_q   <= rsp_v_d;
            rsp_sid_q <= rsp_sid_d;
            rsp_ok_q  <= rsp_ok_d;
            err_q     <= err_d;
        end
    end

    // Outputs are forced quiet for the whole time reset is high, including its first cycle.
    assign i_req_r   = grant ? (ONE_HOT_0 << grant_sid) : '0;
    assign o_req_v   = !reset && req_v_q;
    assign o_req_sid = req_sid_q;
    assign o_rsp_v   = (!reset && rsp_v_q) ? (ONE_HOT_0 << rsp_sid_q) : '0;
    assign o_err     = !reset && err_q;
    assign o_out_cnt = reset ? '0 : out_cnt_q;

endmodule

// File: tb/tb_l1_l2_req_arb.sv
// tb/tb_l1_l2_req_arb.sv - directed self-checking bench for l1_l2_req_arb
module tb_l1_l2_req_arb;

    localparam int NS = 64;
    localparam int SW = 6;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS-1:0] i_req_v;
    logic [NS-1:0] i_req_r;
    logic          o_req_v;
    logic          o_req_r;
    logic [SW-1:0] o_req_sid;
    logic          i_rsp_v;
    logic          i_rsp_r;
    logic [SW-1:0] i_rsp_sid;
    logic [NS-1:0] o_rsp_v;
    logic [NS-1:0] o_rsp_r;
    logic          o_err;
    logic [CW-1:0] o_out_cnt;

    int checks = 0;
    int errors = 0;

    l1_l2_req_arb dut (
        .clk(clk), .reset(reset),
        .i_req_v(i_req_v), .i_req_r(i_req_r),
        .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_sid(o_req_sid),
        .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_sid(i_rsp_sid),
        .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r),
        .o_err(o_err), .o_out_cnt(o_out_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [NS-1:0] oh(input int k);
        logic [NS-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; i_req_v = '0; o_req_r = 1'b0; i_rsp_v = 1'b0; i_rsp_sid = '0; o_rsp_r = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; i_req_v = '1; o_req_r = 1'b1; i_rsp_v = 1'b1; i_rsp_sid = 6'd3; o_rsp_r = '1;
        tick(); #2;
        checks++; if (i_req_r !== '0) begin errors++; $display("FAIL reset_i_req_r got %h exp 0", i_req_r); end
        checks++; if (o_req_v !== 1'b0) begin errors++; $display("FAIL reset_o_req_v got %b exp 0", o_req_v); end
        checks++; if (i_rsp_r !== 1'b0) begin errors++; $display("FAIL reset_i_rsp_r got %b exp 0", i_rsp_r); end
        checks++; if (o_rsp_v !== '0) begin errors++; $display("FAIL reset_o_rsp_v got %h exp 0", o_rsp_v); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_o_err got %b exp 0", o_err); end
        checks++; if (o_out_cnt !== 4'd0) begin errors++; $display("FAIL reset_out_cnt got %0d exp 0", o_out_cnt); end
    endtask

    task automatic test_basic;
        do_reset();
        i_req_v = oh(3) | oh(10); o_req_r = 1'b1;
        #2;
        checks++; if (i_req_r !== oh(3)) begin errors++; $display("FAIL basic_grant3 got %h exp %h", i_req_r, oh(3)); end
        tick(); #2;
        checks++; if (o_req_v !== 1'b1 || o_req_sid !== 6'd3) begin errors++; $display("FAIL basic_req3 got v=%b sid=%0d exp v=1 sid=3", o_req_v, o_req_sid); end
        checks++; if (i_req_r !== oh(10)) begin errors++; $display("FAIL basic_grant10 got %h exp %h", i_req_r, oh(10)); end
        tick(); #2;
        checks++; if (o_req_v !== 1'b1 || o_req_sid !== 6'd10) begin errors++; $display("FAIL basic_req10 got v=%b sid=%0d exp v=1 sid=10", o_req_v, o_req_sid); end
        checks++; if (i_req_r !== '0) begin errors++; $display("FAIL basic_no_regrant got %h exp 0", i_req_r); end
        tick();
        o_rsp_r = '1; i_rsp_v = 1'b1; i_rsp_sid = 6'd3;
        #2;
        checks++; if (o_req_v !== 1'b0 || o_out_cnt !== 4'd2 || i_req_r !== '0) begin errors++; $display("FAIL basic_idle got v=%b cnt=%0d rr=%h exp v=0 cnt=2 rr=0", o_req_v, o_out_cnt, i_req_r); end
        tick();
        i_rsp_v = 1'b0;
        #2;
        checks++; if (o_rsp_v !== oh(3)) begin errors++; $display("FAIL basic_rsp3 got %h exp %h", o_rsp_v, oh(3)); end
        checks++; if (i_req_r !== '0) begin errors++; $display("FAIL basic_same_cycle_regrant got %h exp 0", i_req_r); end
        tick(); #2;
        checks++; if (i_req_r !== oh(3) || o_out_cnt !== 4'd1) begin errors++; $display("FAIL basic_regrant3 got rr=%h cnt=%0d exp rr=%h cnt=1", i_req_r, o_out_cnt, oh(3)); end
    endtask

    task automatic test_rr_fairness;
        do_reset();
        i_req_v = '1; o_req_r = 1'b1; o_rsp_r = '1;
        for (int n = 0; n <= 64; n++) begin
            if (n > 0) tick();
            i_rsp_v = o_req_v; i_rsp_sid = o_req_sid;
            #2;
            checks++; if (i_req_r !== oh(n % 64)) begin errors++; $display("FAIL rr_order n=%0d got %h exp %h", n, i_req_r, oh(n % 64)); end
        end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rr_err got %b exp 0", o_err); end
    endtask

    task automatic test_credit;
        int grants;
        do_reset();
        i_req_v = 64'hFFF; o_req_r = 1'b1;
        grants = 0;
        for (int n = 0; n < 12; n++) begin
            if (n > 0) tick();
            #2;
            grants += $countones(i_req_r);
        end
        checks++; if (grants !== 8) begin errors++; $display("FAIL credit_grants got %0d exp 8", grants); end
        tick(); #2;
        checks++; if (o_out_cnt !== 4'd8 || i_req_r !== '0) begin errors++; $display("FAIL credit_full got cnt=%0d rr=%h exp cnt=8 rr=0", o_out_cnt, i_req_r); end
        i_rsp_v = 1'b1; i_rsp_sid = 6'd0; o_rsp_r = '1;
        tick();
        i_rsp_v = 1'b0;
        #2;
        checks++; if (o_rsp_v !== oh(0) || i_req_r !== '0) begin errors++; $display("FAIL credit_rsp got rsp=%h rr=%h exp rsp=%h rr=0", o_rsp_v, i_req_r, oh(0)); end
        tick(); #2;
        checks++; if (o_out_cnt !== 4'd7 || i_req_r !== oh(8)) begin errors++; $display("FAIL credit_regrant got cnt=%0d rr=%h exp cnt=7 rr=%h", o_out_cnt, i_req_r, oh(8)); end
        tick(); #2;
        checks++; if (o_out_cnt !== 4'd8 || i_req_r !== '0) begin errors++; $display("FAIL credit_refull got cnt=%0d rr=%h exp cnt=8 rr=0", o_out_cnt, i_req_r); end
    endtask

    task automatic test_backpressure;
        do_reset();
        i_req_v = oh(5) | oh(6); o_req_r = 1'b0;
        tick();
        for (int n = 0; n < 5; n++) begin
            #2;
            checks++; if (o_req_v !== 1'b1 || o_req_sid !== 6'd5 || i_req_r !== '0) begin errors++; $display("FAIL bp_hold n=%0d got v=%b sid=%0d rr=%h exp v=1 sid=5 rr=0", n, o_req_v, o_req_sid, i_req_r); end
            tick();
        end
        o_req_r = 1'b1;
        #2;
        checks++; if (i_req_r !== oh(6)) begin errors++; $display("FAIL bp_drain_grant got %h exp %h", i_req_r, oh(6)); end
        tick();
        i_req_v = '0;
        #2;
        checks++; if (o_req_sid !== 6'd6 || o_req_v !== 1'b1) begin errors++; $display("FAIL bp_req6 got v=%b sid=%0d exp v=1 sid=6", o_req_v, o_req_sid); end
        i_rsp_v = 1'b1; i_rsp_sid = 6'd5; o_rsp_r = '0;
        tick();
        i_rsp_sid = 6'd6;
        #2;
        checks++; if (o_rsp_v !== oh(5) || i_rsp_r !== 1'b0) begin errors++; $display("FAIL bp_rsp_stall got rsp=%h r=%b exp rsp=%h r=0", o_rsp_v, i_rsp_r, oh(5)); end
        tick(); #2;
        checks++; if (o_rsp_v !== oh(5) || i_rsp_r !== 1'b0) begin errors++; $display("FAIL bp_rsp_stall2 got rsp=%h r=%b exp rsp=%h r=0", o_rsp_v, i_rsp_r, oh(5)); end
        o_rsp_r = oh(5);
        #1;
        checks++; if (i_rsp_r !== 1'b1) begin errors++; $display("FAIL bp_rsp_release got %b exp 1", i_rsp_r); end
        tick();
        i_rsp_v = 1'b0;
        #2;
        checks++; if (o_rsp_v !== oh(6) || o_out_cnt !== 4'd1) begin errors++; $display("FAIL bp_rsp6 got rsp=%h cnt=%0d exp rsp=%h cnt=1", o_rsp_v, o_out_cnt, oh(6)); end
    endtask

    task automatic test_err;
        do_reset();
        i_rsp_v = 1'b1; i_rsp_sid = 6'd20; o_rsp_r = '0;
        #2;
        checks++; if (i_rsp_r !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL err_accept got r=%b err=%b exp r=1 err=0", i_rsp_r, o_err); end
        tick();
        i_rsp_v = 1'b0;
        #2;
        checks++; if (o_err !== 1'b1 || o_rsp_v !== oh(20) || o_out_cnt !== 4'd0) begin errors++; $display("FAIL err_set got err=%b rsp=%h cnt=%0d exp err=1 rsp=%h cnt=0", o_err, o_rsp_v, o_out_cnt, oh(20)); end
        o_rsp_r = '1;
        tick(); tick(); tick(); #2;
        checks++; if (o_err !== 1'b1 || o_rsp_v !== '0 || o_out_cnt !== 4'd0) begin errors++; $display("FAIL err_sticky got err=%b rsp=%h cnt=%0d exp err=1 rsp=0 cnt=0", o_err, o_rsp_v, o_out_cnt); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", o_err); end
    endtask

    task automatic test_simul_and_reset;
        do_reset();
        i_req_v = 64'hF; o_req_r = 1'b1; o_rsp_r = '1;
        tick(); tick(); tick(); tick();
        i_req_v = '0; i_rsp_v = 1'b1; i_rsp_sid = 6'd0;
        #2;
        checks++; if (o_out_cnt !== 4'd4) begin errors++; $display("FAIL sim_cnt4 got %0d exp 4", o_out_cnt); end
        tick();
        i_rsp_v = 1'b0; i_req_v = oh(4);
        #2;
        checks++; if (i_req_r !== oh(4) || o_rsp_v !== oh(0) || o_out_cnt !== 4'd4) begin errors++; $display("FAIL sim_both got rr=%h rsp=%h cnt=%0d exp rr=%h rsp=%h cnt=4", i_req_r, o_rsp_v, o_out_cnt, oh(4), oh(0)); end
        tick();
        i_req_v = '0; i_rsp_v = 1'b1; i_rsp_sid = 6'd1;
        #2;
        checks++; if (o_out_cnt !== 4'd4) begin errors++; $display("FAIL sim_stay4 got %0d exp 4", o_out_cnt); end
        tick();
        i_rsp_v = 1'b0;
        tick();
        o_rsp_r = '0; i_rsp_v = 1'b1; i_rsp_sid = 6'd2;
        #2;
        checks++; if (o_out_cnt !== 4'd3) begin errors++; $display("FAIL sim_cnt3 got %0d exp 3", o_out_cnt); end
        tick();
        reset = 1'b1; i_rsp_v = 1'b0; i_req_v = '1;
        #2;
        checks++; if (o_out_cnt !== 4'd0 || o_req_v !== 1'b0 || o_rsp_v !== '0 || i_req_r !== '0 || i_rsp_r !== 1'b0) begin errors++; $display("FAIL sim_reset got cnt=%0d qv=%b rsp=%h rr=%h sr=%b exp all 0", o_out_cnt, o_req_v, o_rsp_v, i_req_r, i_rsp_r); end
        tick();
        reset = 1'b0; i_req_v = oh(2);
        #2;
        checks++; if (i_req_r !== oh(2) || o_out_cnt !== 4'd0 || o_rsp_v !== '0) begin errors++; $display("FAIL sim_post_reset got rr=%h cnt=%0d rsp=%h exp rr=%h cnt=0 rsp=0", i_req_r, o_out_cnt, o_rsp_v, oh(2)); end
    endtask

    initial begin
        reset = 1'b1; i_req_v = '0; o_req_r = 1'b0; i_rsp_v = 1'b0; i_rsp_sid = '0; o_rsp_r = '0;
        test_reset();
        test_basic();
        test_rr_fairness();
        test_credit();
        test_backpressure();
        test_err();
        test_simul_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l1_l2_req_arb.md
L1_L2_REQ_ARB -- requirements
Module: l1_l2_req_arb

Interface
REQ-001 Parameter nstrms, default 64, total number of streams (power of two, >=2).
REQ-002 Parameter sid_width, default $clog2(nstrms), stream id width.
REQ-003 Parameter max_out, default 8, maximum L2 cacheline requests in flight (1..nstrms).
REQ-004 Parameter cnt_width, default $clog2(max_out+1), width of the outstanding counter.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 i_req_v  input  nstrms  per-stream cacheline request valid, driven by the L1 stream pointer logic.
REQ-009 i_req_r  output  nstrms  per-stream request ready, one-hot or zero.
REQ-010 o_req_v  output  1  arbitrated L2 request valid.
REQ-011 o_req_r  input  1  L2 request ready.
REQ-012 o_req_sid  output  sid_width  stream id of the arbitrated request.
REQ-013 i_rsp_v  input  1  L2 cacheline response valid.
REQ-014 i_rsp_r  output  1  L2 response ready.
REQ-015 i_rsp_sid  input  sid_width  stream id of the response.
REQ-016 o_rsp_v  output  nstrms  per-stream response valid, one-hot or zero.
REQ-017 o_rsp_r  input  nstrms  per-stream response ready.
REQ-018 o_err  output  1  sticky protocol error: response for a stream with no pending request.
REQ-019 o_out_cnt  output  cnt_width  current number of requests in flight.

Function
REQ-020 A stream is eligible when i_req_v[i]=1 and pend[i]=0.
REQ-021 A grant is issued in a cycle when at least one stream is eligible, out_cnt<max_out, and the request register is empty or is being drained (o_req_v & o_req_r) in that same cycle.
REQ-022 Arbitration is round-robin: search starts at rr_ptr and wraps modulo nstrms; the first eligible stream wins.
REQ-023 On a grant to stream k: i_req_r[k]=1 combinationally in that cycle, rr_ptr becomes (k+1) mod nstrms, pend[k] is set, and the request register loads sid k.
REQ-024 No grant leaves rr_ptr unchanged; i_req_r is all-zero in non-grant cycles.
REQ-025 Request latency: a grant in cycle t gives o_req_v=1 with o_req_sid=k in cycle t+1; o_req_v and o_req_sid stay stable until o_req_r=1.
REQ-026 The response register is one entry deep. i_rsp_r = register empty OR the held response is accepted by its stream in this cycle.
REQ-027 A response accepted in cycle t (i_rsp_v & i_rsp_r) gives o_rsp_v[i_rsp_sid]=1 in cycle t+1, held until o_rsp_r for that stream is 1.
REQ-028 On per-stream response handshake for stream s: pend[s] clears and out_cnt decrements.
REQ-029 out_cnt increments on grant and decrements on response handshake; both in one cycle leave it unchanged; the value never exceeds max_out and never underflows.
REQ-030 Stream s may be re-granted in the cycle after its pend bit clears, never in the same cycle.
REQ-031 A response accepted with pend[i_rsp_sid]=0 sets o_err until reset; the response is still delivered, and out_cnt and pend are not modified at its delivery.
REQ-032 At most one request per stream is in flight; responses may return in any stream order.

Reset
REQ-033 While reset=1: o_req_v=0, o_rsp_v=0, i_req_r=0, i_rsp_r=0, o_err=0, o_out_cnt=0, rr_ptr=0, pend=0.
REQ-034 Reset mid-operation discards held request and response registers and all in-flight accounting; first grant is possible in the first cycle after reset deasserts.

Verification
REQ-035 After reset, i_req_v[3]=1 and i_req_v[10]=1 held, o_req_r=1 -> o_req_sid 3 then 10 on consecutive cycles; neither re-granted until responses are delivered.
REQ-036 Round-robin fairness: all 64 streams requesting, immediate responses -> grants 0,1,...,63,0 in order; no stream granted twice within 64 grants.
REQ-037 Credit limit max_out=8: 12 streams requesting, no responses -> exactly 8 grants, o_out_cnt=8, i_req_r all-zero after; one response delivered -> o_out_cnt=7 and one more grant next cycle.
REQ-038 Backpressure: o_req_r=0 for 5 cycles with o_req_v=1 -> o_req_sid stable, no further grants; o_rsp_r[5]=0 with response held for stream 5 -> i_rsp_r=0, second response stalled.
REQ-039 Response i_rsp_sid=20 with pend[20]=0 -> o_err=1, o_rsp_v[20]=1 next cycle, o_out_cnt unchanged; o_err remains 1 until reset.
REQ-040 Simultaneous grant and response handshake at o_out_cnt=4 -> o_out_cnt stays 4; reset asserted with 3 in flight -> all outputs zero next cycle, o_out_cnt=0.
